// File: rtl/fifo_wr_arbiter_if.sv
// Requester-to-FIFO write bus shared by the arbiter and its environment.
// The master side drives requester words and the FIFO full flag; the slave
// side (the arbiter) returns per-requester ready and the FIFO write port.
interface fifo_wr_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_wr_data;
    logic                          fifo_full;

    modport master (
        output req_valid,
        output req_data,
        output req_last,
        output fifo_full,
        input  req_ready,
        input  fifo_wr_en,
        input  fifo_wr_data
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_last,
        input  fifo_full,
        output req_ready,
        output fifo_wr_en,
        output fifo_wr_data
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of an async FIFO write port.
// One requester owns the port per grant; a grant ends on its packet's last
// word or after MAX_BURST beats, and one idle cycle separates grants.
// The FIFO write strobe is combinational so no bubble is added per beat.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 16,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                wr_clk,
    input  logic                wr_rst,
    fifo_wr_arbiter_if.slave    bus,
    output logic                grant_valid,
    output logic [ID_W-1:0]     grant_id,
    output logic [8:0]          beat_cnt
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] grant_id_q, grant_id_d;
    logic [8:0]      beat_cnt_q, beat_cnt_d;

    logic [ID_W-1:0] winner;
    int              idx;
    logic            gnt_valid;
    logic            gnt_last;
    logic            beat;
    logic            burst_end;

    // Pointer to the requester after the current owner, wrapping at NUM_REQ.
    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
        if (id == ID_W'(NUM_REQ - 1)) begin
            return '0;
        end
        return id + ID_W'(1);
    endfunction

    // Round-robin search: scan from farthest to nearest offset so the
    // closest valid requester at or above rr_ptr wins.
    always_comb begin
        winner = rr_ptr_q;
        idx    = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (bus.req_valid[ID_W'(idx)]) begin
                winner = ID_W'(idx);
            end
        end
    end

    assign gnt_valid = bus.req_valid[grant_id_q];
    assign gnt_last  = bus.req_last[grant_id_q];
    assign beat      = (state_q == XFER) & gnt_valid & ~bus.fifo_full;
    assign burst_end = (({1'b0, beat_cnt_q} + 10'd1) == 10'(MAX_BURST));

    // Only the owner sees ready, and only while the FIFO can take a word.
    always_comb begin
        bus.req_ready = '0;
        if (state_q == XFER) begin
            bus.req_ready[grant_id_q] = ~bus.fifo_full;
        end
    end

    assign bus.fifo_wr_en   = beat;
    assign bus.fifo_wr_data = bus.req_data[int'(grant_id_q) * DATA_WIDTH +: DATA_WIDTH];

    assign grant_valid = (state_q == XFER);
    assign grant_id    = grant_id_q;
    assign beat_cnt    = beat_cnt_q;

    // Next-state logic: arbitrate in IDLE, count beats and close the grant in XFER.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    state_d    = XFER;
                    grant_id_d = winner;
                    beat_cnt_d = '0;
                end
            end
            XFER: begin
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + 9'd1;
                    if (gnt_last || burst_end) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_ptr(grant_id_q);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset abandons any grant at once.
    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: scripted requester sources, a write
// log captured mid-cycle, and hand-computed expected grant/beat sequences.
module tb_fifo_wr_arbiter;
    localparam int DW = 32;
    localparam int NR = 4;
    localparam int MB = 4;

    logic       wr_clk = 1'b0;
    logic       wr_rst;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic [8:0] beat_cnt;

    fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
        .wr_clk      (wr_clk),
        .wr_rst      (wr_rst),
        .bus         (bus),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .beat_cnt    (beat_cnt)
    );

    always #5 wr_clk = ~wr_clk;

    int   checks = 0;
    int   errors = 0;
    int   rem [NR];
    int   seq [NR];
    logic single [NR];
    logic hold [NR];
    int   cyc = 0;
    logic prev_gv = 1'b0;
    int   idle_run = 0;
    int   cur_beats = 0;

    logic [31:0] wdata [$];
    int          wgid [$];
    int          wbeat [$];
    int          wcyc [$];
    int          glog [$];
    int          blog [$];
    int          ilog [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word(input int r, input int k);
        return {4'hA, 4'(r), 8'h00, 16'(k)};
    endfunction

    task automatic drive();
        for (int r = 0; r < NR; r++) begin
            bus.req_valid[r]         = (rem[r] > 0) && !hold[r];
            bus.req_last[r]          = single[r] || (rem[r] == 1);
            bus.req_data[r*DW +: DW] = word(r, seq[r]);
        end
    endtask

    task automatic clear_logs();
        wdata.delete(); wgid.delete(); wbeat.delete(); wcyc.delete();
        glog.delete(); blog.delete(); ilog.delete();
        cur_beats = 0;
        idle_run  = 0;
    endtask

    task automatic tick();
        logic [NR-1:0] acc;
        @(negedge wr_clk);
        acc = bus.req_valid & bus.req_ready;
        if (bus.fifo_wr_en) begin
            wdata.push_back(bus.fifo_wr_data);
            wgid.push_back(int'(grant_id));
            wbeat.push_back(int'(beat_cnt));
            wcyc.push_back(cyc);
            cur_beats++;
        end
        if (grant_valid && !prev_gv) begin
            glog.push_back(int'(grant_id));
            ilog.push_back(idle_run);
        end
        if (!grant_valid && prev_gv) begin
            blog.push_back(cur_beats);
            cur_beats = 0;
        end
        idle_run = grant_valid ? 0 : idle_run + 1;
        prev_gv  = grant_valid;
        cyc++;
        @(posedge wr_clk);
        #1;
        for (int r = 0; r < NR; r++) begin
            if (acc[r]) begin
                rem[r]--;
                seq[r]++;
            end
        end
        drive();
    endtask

    function automatic bit busy();
        bit b = grant_valid;
        for (int r = 0; r < NR; r++) begin
            if (rem[r] > 0) b = 1'b1;
        end
        return b;
    endfunction

    task automatic run_idle(input int maxc);
        int n = 0;
        while (busy() && n < maxc) begin
            tick();
            n++;
        end
        if (busy()) chk("timeout", 0, 1);
        tick();
    endtask

    task automatic wait_writes(input int nw, input string tag);
        int n = 0;
        while (wdata.size() < nw && n < 40) begin
            tick();
            n++;
        end
        chk(tag, wdata.size(), nw);
    endtask

    task automatic do_reset();
        wr_rst = 1'b1;
        for (int r = 0; r < NR; r++) begin
            rem[r] = 0; seq[r] = 0; single[r] = 1'b0; hold[r] = 1'b0;
        end
        bus.fifo_full = 1'b0;
        drive();
        repeat (2) begin
            @(posedge wr_clk);
            #1;
        end
        wr_rst  = 1'b0;
        prev_gv = 1'b0;
        clear_logs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state with requests pending
        wr_rst = 1'b1;
        bus.fifo_full = 1'b0;
        for (int r = 0; r < NR; r++) begin
            rem[r] = 0; seq[r] = 0; single[r] = 1'b0; hold[r] = 1'b0;
        end
        rem[0] = 2; rem[2] = 1;
        drive();
        repeat (3) begin
            @(posedge wr_clk);
            #1;
        end
        chk("rst_gv",    grant_valid, 0);
        chk("rst_gid",   grant_id, 0);
        chk("rst_beat",  beat_cnt, 0);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_wren",  bus.fifo_wr_en, 0);

        // Single requester, 3-word packet
        do_reset();
        rem[2] = 3;
        drive();
        run_idle(30);
        chk("t1_nwr", wdata.size(), 3);
        chk("t1_ngrant", glog.size(), 1);
        if (wdata.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                chk("t1_data", wdata[k], word(2, k));
                chk("t1_gid", wgid[k], 2);
                chk("t1_beat", wbeat[k], k);
            end
            chk("t1_consec", wcyc[2] - wcyc[0], 2);
        end

        // rr_ptr now 3: requester 3 wins over 0
        clear_logs();
        rem[0] = 1; rem[3] = 1;
        drive();
        run_idle(30);
        chk("t2_ngrant", glog.size(), 2);
        if (glog.size() == 2) begin
            chk("t2_first", glog[0], 3);
            chk("t2_second", glog[1], 0);
        end

        // Fairness with 1-word packets on all requesters
        do_reset();
        for (int r = 0; r < NR; r++) begin
            rem[r] = 2; single[r] = 1'b1;
        end
        drive();
        run_idle(60);
        chk("t3_nwr", wdata.size(), 8);
        chk("t3_ngrant", glog.size(), 8);
        if (glog.size() == 8) begin
            for (int k = 0; k < 8; k++) chk("t3_order", glog[k], k % 4);
            for (int k = 1; k < 8; k++) chk("t3_idle", ilog[k], 1);
        end

        // Burst cap of 4 on a 10-word packet, interleaved
        do_reset();
        rem[1] = 10;
        rem[2] = 2; single[2] = 1'b1;
        rem[3] = 2; single[3] = 1'b1;
        drive();
        run_idle(80);
        chk("t4_ngrant", glog.size(), 7);
        chk("t4_nburst", blog.size(), 7);
        if (glog.size() == 7 && blog.size() == 7) begin
            int eg [7] = '{1, 2, 3, 1, 2, 3, 1};
            int eb [7] = '{4, 1, 1, 4, 1, 1, 2};
            for (int k = 0; k < 7; k++) begin
                chk("t4_gid", glog[k], eg[k]);
                chk("t4_beats", blog[k], eb[k]);
            end
        end
        begin
            int n1 = 0;
            for (int k = 0; k < wdata.size(); k++) begin
                if (wgid[k] == 1) begin
                    chk("t4_r1data", wdata[k], word(1, n1));
                    n1++;
                end
            end
            chk("t4_r1count", n1, 10);
        end

        // Backpressure for 5 cycles mid-packet
        do_reset();
        rem[0] = 4;
        drive();
        wait_writes(2, "t5_start");
        bus.fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t5_ready", bus.req_ready, 0);
            chk("t5_wren", bus.fifo_wr_en, 0);
            chk("t5_beat", beat_cnt, 2);
            chk("t5_gv", grant_valid, 1);
            tick();
        end
        bus.fifo_full = 1'b0;
        #1;
        chk("t5_resume", bus.fifo_wr_en, 1);
        chk("t5_ready_on", bus.req_ready, 4'b0001);
        run_idle(30);
        chk("t5_nwr", wdata.size(), 4);
        if (wdata.size() == 4) begin
            for (int k = 0; k < 4; k++) chk("t5_data", wdata[k], word(0, k));
        end

        // Reset at beat 2 of a 6-beat packet
        do_reset();
        rem[2] = 6;
        drive();
        wait_writes(2, "t6_start");
        #1;
        chk("t6_pre_wren", bus.fifo_wr_en, 1);
        wr_rst = 1'b1;
        rem[1] = 1; rem[3] = 1;
        drive();
        #1;
        chk("t6_rst_wren", bus.fifo_wr_en, 0);
        chk("t6_rst_gv", grant_valid, 0);
        chk("t6_rst_ready", bus.req_ready, 0);
        tick();
        tick();
        chk("t6_nwr_rst", wdata.size(), 2);
        wr_rst = 1'b0;
        #1;
        chk("t6_post_gv", grant_valid, 0);
        tick();
        chk("t6_next_gv", grant_valid, 1);
        chk("t6_next_gid", grant_id, 1);
        run_idle(40);

        // Valid gap of 3 cycles on the owner while others wait
        do_reset();
        rem[0] = 3; rem[1] = 2; rem[2] = 2;
        drive();
        wait_writes(2, "t7_start");
        hold[0] = 1'b1;
        drive();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t7_gv", grant_valid, 1);
            chk("t7_gid", grant_id, 0);
            chk("t7_wren", bus.fifo_wr_en, 0);
            tick();
        end
        hold[0] = 1'b0;
        drive();
        run_idle(40);
        chk("t7_nwr", wdata.size(), 7);
        if (wdata.size() == 7) begin
            for (int k = 0; k < 3; k++) chk("t7_r0data", wdata[k], word(0, k));
            chk("t7_r1data", wdata[3], word(1, 0));
        end
        chk("t7_ngrant", glog.size(), 3);
        if (glog.size() == 3) begin
            for (int k = 0; k < 3; k++) chk("t7_order", glog[k], k);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
